tpu_instr_sequencer: RTL and testbench

Instruction sequencer between the TPU instruction queue and the unified-buffer/accumulator datapath. Accepts one 80-bit TPU instruction at a time, decodes its opcode, and expands it into `length` per-row datapath commands. Each command carries an incrementing unified-buffer address and accumulator address. Reports completion, illegal opcodes and halt.

---
 rtl/tpu_instr_sequencer.sv | 246 ++++++++++++++++++++++++
 tb/tb_tpu_instr_sequencer.sv | 491 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tpu_instr_sequencer.sv
// tpu_instr_sequencer
//
// Sits between the TPU instruction queue and the unified-buffer/accumulator
// datapath. It accepts one 80-bit instruction at a time, decodes the opcode,
// and expands data opcodes into `length` per-row commands. Each command
// carries an incrementing unified-buffer address and accumulator address.
//
// Instruction fields: [79:56] buffer_addr, [55:40] acc_addr,
//                     [39:8]  length,      [7:0]   opcode
// Opcodes: 0x00 NOP, 0x01 LOAD_WEIGHTS, 0x02 MATMUL, 0x03 MATMUL_ACC,
//          0xFF HALT, anything else is dropped as illegal.
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   instr_valid  instruction offered
//   instr_ready  sequencer is IDLE and can take an instruction
//   instr        80-bit instruction
//   cmd_valid    datapath command valid (high throughout ISSUE)
//   cmd_ready    datapath accepts command
//   cmd_op       01 LOAD_WEIGHTS, 10 MATMUL, 11 MATMUL_ACC
//   cmd_buf_addr unified-buffer row address (wraps)
//   cmd_acc_addr accumulator row address (wraps)
//   cmd_last     final command of the current instruction
//   busy         high while in ISSUE
//   done         one-cycle pulse when an instruction retires
//   illegal      one-cycle pulse when an unknown opcode is dropped
//   halted       high in HALT; only reset leaves it
//   busy_cycles  saturating count of ISSUE cycles
//
// Build option: define TPU_SEQ_PERF_COUNTER_EN to generate the busy_cycles
// counter; otherwise busy_cycles is tied to zero.

module tpu_instr_sequencer #(
    parameter int unsigned BUF_ADDR_WIDTH = 24,
    parameter int unsigned ACC_ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH      = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      instr_valid,
    output logic                      instr_ready,
    input  logic [79:0]               instr,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [1:0]                cmd_op,
    output logic [BUF_ADDR_WIDTH-1:0] cmd_buf_addr,
    output logic [ACC_ADDR_WIDTH-1:0] cmd_acc_addr,
    output logic                      cmd_last,
    output logic                      busy,
    output logic                      done,
    output logic                      illegal,
    output logic                      halted,
    output logic [31:0]               busy_cycles
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    state_t                    r_state;
    state_t                    w_next_state;

    logic [1:0]                r_op;
    logic [BUF_ADDR_WIDTH-1:0] r_buf_addr;
    logic [ACC_ADDR_WIDTH-1:0] r_acc_addr;
    logic [LEN_WIDTH-1:0]      r_rem;
    logic                      r_done;
    logic                      r_illegal;

    logic [7:0]                w_opcode;
    logic [BUF_ADDR_WIDTH-1:0] w_buf_addr;
    logic [ACC_ADDR_WIDTH-1:0] w_acc_addr;
    logic [LEN_WIDTH-1:0]      w_len;
    logic                      w_is_nop;
    logic                      w_is_data;
    logic                      w_is_halt;
    logic                      w_len_zero;
    logic                      w_accept;
    logic                      w_last;
    logic                      w_fire;

    // ------------------------------------------------------------------
    // Instruction field extraction and opcode decode
    // ------------------------------------------------------------------
    always_comb begin
        w_opcode   = instr[7:0];
        w_buf_addr = BUF_ADDR_WIDTH'(instr[79:56]);
        w_acc_addr = ACC_ADDR_WIDTH'(instr[55:40]);
        w_len      = LEN_WIDTH'(instr[39:8]);
        w_is_nop   = (w_opcode == 8'h00);
        w_is_data  = (w_opcode == 8'h01) || (w_opcode == 8'h02) ||
                     (w_opcode == 8'h03);
        w_is_halt  = (w_opcode == 8'hFF);
        w_len_zero = (w_len == '0);
    end

    always_comb begin
        w_accept = instr_valid && (r_state == ST_IDLE);
        w_last   = (r_state == ST_ISSUE) && (r_rem == LEN_WIDTH'(1));
        w_fire   = (r_state == ST_ISSUE) && cmd_ready;
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_is_halt) begin
                        w_next_state = ST_HALT;
                    end else if (w_is_data && !w_len_zero) begin
                        w_next_state = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                if (w_fire && w_last) begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_HALT: begin
                w_next_state = ST_HALT;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs. Command fields are forced to zero outside ISSUE so the
    // datapath never sees stale addresses between instructions.
    // ------------------------------------------------------------------
    always_comb begin
        instr_ready  = 1'b0;
        busy         = 1'b0;
        halted       = 1'b0;
        cmd_valid    = 1'b0;
        cmd_op       = '0;
        cmd_buf_addr = '0;
        cmd_acc_addr = '0;
        cmd_last     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = 1'b1;
            end
            ST_ISSUE: begin
                busy         = 1'b1;
                cmd_valid    = 1'b1;
                cmd_op       = r_op;
                cmd_buf_addr = r_buf_addr;
                cmd_acc_addr = r_acc_addr;
                cmd_last     = w_last;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                instr_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Instruction latch, address/remaining-count stepping, status pulses
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op       <= '0;
            r_buf_addr <= '0;
            r_acc_addr <= '0;
            r_rem      <= '0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
        end else begin
            r_done    <= 1'b0;
            r_illegal <= 1'b0;

            if (w_accept) begin
                // NOP and zero-length data opcodes retire without issuing.
                if (w_is_nop || (w_is_data && w_len_zero)) begin
                    r_done <= 1'b1;
                end
                if (!w_is_nop && !w_is_data && !w_is_halt) begin
                    r_illegal <= 1'b1;
                end
                if (w_is_data && !w_len_zero) begin
                    // Data opcodes 0x01..0x03 map directly onto cmd_op.
                    r_op       <= w_opcode[1:0];
                    r_buf_addr <= w_buf_addr;
                    r_acc_addr <= w_acc_addr;
                    r_rem      <= w_len;
                end
            end

            if (w_fire) begin
                // Natural modulo-2^width wrap on both addresses.
                r_buf_addr <= r_buf_addr + BUF_ADDR_WIDTH'(1);
                r_acc_addr <= r_acc_addr + ACC_ADDR_WIDTH'(1);
                r_rem      <= r_rem - LEN_WIDTH'(1);
                if (w_last) begin
                    r_done <= 1'b1;
                end
            end
        end
    end

    assign done    = r_done;
    assign illegal = r_illegal;

    // ------------------------------------------------------------------
    // Optional performance counter: cycles spent in ISSUE, stalls included
    // ------------------------------------------------------------------
`ifdef TPU_SEQ_PERF_COUNTER_EN
    logic [31:0] r_busy_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy_cycles <= '0;
        end else if ((r_state == ST_ISSUE) && (r_busy_cycles != '1)) begin
            r_busy_cycles <= r_busy_cycles + 32'd1;
        end
    end

    assign busy_cycles = r_busy_cycles;
`else
    assign busy_cycles = '0;
`endif

endmodule

// File: tb/tb_tpu_instr_sequencer.sv
// Self-checking bench for tpu_instr_sequencer.
// Expected commands are queued as each instruction is driven; a negedge
// monitor records observed handshakes, pulses and cycle stamps, and each
// test task compares the two.

module tb_tpu_instr_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [79:0] instr = '0;
    logic        cmd_valid;
    logic        cmd_ready = 1'b0;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_buf_addr;
    logic [15:0] cmd_acc_addr;
    logic        cmd_last;
    logic        busy;
    logic        done;
    logic        illegal;
    logic        halted;
    logic [31:0] busy_cycles;

    tpu_instr_sequencer #(
        .BUF_ADDR_WIDTH(24),
        .ACC_ADDR_WIDTH(16),
        .LEN_WIDTH(32)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .instr(instr),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op(cmd_op),
        .cmd_buf_addr(cmd_buf_addr),
        .cmd_acc_addr(cmd_acc_addr),
        .cmd_last(cmd_last),
        .busy(busy),
        .done(done),
        .illegal(illegal),
        .halted(halted),
        .busy_cycles(busy_cycles)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [1:0]  op;
        logic [23:0] b;
        logic [15:0] a;
        logic        last;
    } cmd_t;

    cmd_t        exp_q[$];
    cmd_t        obs_q[$];
    int unsigned obs_cyc_q[$];
    int unsigned acc_cyc_q[$];

    int unsigned cyc = 0;
    int unsigned done_cnt = 0;
    int unsigned ill_cnt = 0;
    int unsigned both_cnt = 0;
    int unsigned valid_cnt = 0;
    int unsigned last_done_cyc = 0;
    logic        ready_at_done = 1'b0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    logic [31:0] exp_busy = 32'd0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (instr_valid && instr_ready) acc_cyc_q.push_back(cyc);
            if (cmd_valid) valid_cnt++;
            if (cmd_valid && cmd_ready) begin
                obs_q.push_back('{cmd_op, cmd_buf_addr, cmd_acc_addr, cmd_last});
                obs_cyc_q.push_back(cyc);
            end
            if (done) begin
                done_cnt++;
                last_done_cyc = cyc;
                ready_at_done = instr_ready;
            end
            if (illegal) ill_cnt++;
            if (done && illegal) both_cnt++;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    function automatic logic [31:0] exp_bc();
`ifdef TPU_SEQ_PERF_COUNTER_EN
        return exp_busy;
`else
        return 32'd0;
`endif
    endfunction

    task automatic clear_queues();
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
        acc_cyc_q.delete();
    endtask

    task automatic push_cmds(input logic [1:0] op, input logic [23:0] b,
                             input logic [15:0] a, input int unsigned len);
        logic [23:0] bb;
        logic [15:0] aa;
        bb = b;
        aa = a;
        for (int unsigned i = 0; i < len; i++) begin
            exp_q.push_back('{op, bb, aa, (i == len - 1)});
            bb = bb + 24'd1;
            aa = aa + 16'd1;
        end
    endtask

    // Offers one instruction; returns at posedge+1 after the accept edge,
    // or after 20 unaccepted cycles. instr is scrambled afterwards.
    task automatic send(input logic [7:0] op, input logic [23:0] b,
                        input logic [15:0] a, input logic [31:0] len,
                        output bit accepted);
        accepted = 1'b0;
        @(posedge clk); #1;
        instr = {b, a, len, op};
        instr_valid = 1'b1;
        for (int i = 0; i < 20 && !accepted; i++) begin
            @(negedge clk);
            if (instr_ready) accepted = 1'b1;
            @(posedge clk); #1;
        end
        instr_valid = 1'b0;
        instr = {$urandom(), $urandom(), 16'($urandom())};
    endtask

    task automatic wait_done(input int unsigned target, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (done_cnt >= target) ok = 1'b1;
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        instr_valid = 1'b0;
        cmd_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (instr_ready !== 1'b1) $display("FAIL reset_instr_ready got %b exp 1", instr_ready);
        else n_pass++;
        n_checks++;
        if ({cmd_valid, cmd_op, cmd_buf_addr, cmd_acc_addr, cmd_last} !== 44'd0)
            $display("FAIL reset_cmd got v=%b op=%b buf=%h acc=%h last=%b exp all 0",
                     cmd_valid, cmd_op, cmd_buf_addr, cmd_acc_addr, cmd_last);
        else n_pass++;
        n_checks++;
        if ({busy, done, illegal, halted} !== 4'b0000)
            $display("FAIL reset_status got busy/done/ill/halt=%b exp 0000",
                     {busy, done, illegal, halted});
        else n_pass++;
        n_checks++;
        if (busy_cycles !== 32'd0) $display("FAIL reset_busy_cycles got %0d exp 0", busy_cycles);
        else n_pass++;
        rst_n = 1'b1;
        exp_busy = 32'd0;
        @(posedge clk); #1;
    endtask

    task automatic test_matmul();
        int unsigned d0;
        bit ok;
        bit ok2;
        d0 = done_cnt;
        cmd_ready = 1'b1;
        clear_queues();
        push_cmds(2'b10, 24'h000010, 16'h0020, 4);
        send(8'h02, 24'h000010, 16'h0020, 32'd4, ok);
        wait_done(d0 + 1, ok2);
        exp_busy = exp_busy + 32'd4;
        n_checks++;
        if (!ok || !ok2) $display("FAIL matmul_complete got accepted=%b done_seen=%b exp 1 1", ok, ok2);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cmd_t e;
            cmd_t o;
            n_checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0)
                $display("FAIL matmul_cmd%0d missing got obs=%0d exp=%0d", i, obs_q.size(), exp_q.size());
            else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL matmul_cmd%0d got op=%b buf=%h acc=%h last=%b exp op=%b buf=%h acc=%h last=%b",
                             i, o.op, o.b, o.a, o.last, e.op, e.b, e.a, e.last);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL matmul_extra_cmds got %0d exp 0", obs_q.size());
        else n_pass++;
        n_checks++;
        if (acc_cyc_q.size() < 1 || obs_cyc_q.size() < 1 || obs_cyc_q[0] != acc_cyc_q[0] + 1)
            $display("FAIL matmul_first_latency got cmd_cyc=%0d exp %0d",
                     (obs_cyc_q.size() > 0) ? obs_cyc_q[0] : 0, (acc_cyc_q.size() > 0) ? acc_cyc_q[0] + 1 : 0);
        else n_pass++;
        n_checks++;
        if (acc_cyc_q.size() < 1 || last_done_cyc != acc_cyc_q[0] + 5)
            $display("FAIL matmul_done_cycle got %0d exp %0d", last_done_cyc,
                     (acc_cyc_q.size() > 0) ? acc_cyc_q[0] + 5 : 0);
        else n_pass++;
        n_checks++;
        if (ready_at_done !== 1'b1 || done_cnt != d0 + 1)
            $display("FAIL matmul_done got ready_at_done=%b count=%0d exp 1 %0d", ready_at_done, done_cnt - d0, 1);
        else n_pass++;
        n_checks++;
        if (busy_cycles !== exp_bc()) $display("FAIL matmul_busy_cycles got %0d exp %0d", busy_cycles, exp_bc());
        else n_pass++;
    endtask

    task automatic test_stall();
        int unsigned d0;
        bit ok;
        bit ok2;
        logic [43:0] snap;
        logic [43:0] now;
        d0 = done_cnt;
        cmd_ready = 1'b1;
        clear_queues();
        push_cmds(2'b01, 24'h000100, 16'h0040, 3);
        send(8'h01, 24'h000100, 16'h0040, 32'd3, ok);
        @(posedge clk); #1;
        cmd_ready = 1'b0;
        @(negedge clk);
        snap = {cmd_valid, cmd_op, cmd_buf_addr, cmd_acc_addr, cmd_last};
        n_checks++;
        if (snap !== {1'b1, 2'b01, 24'h000101, 16'h0041, 1'b0})
            $display("FAIL stall_presented got %h exp %h", snap, {1'b1, 2'b01, 24'h000101, 16'h0041, 1'b0});
        else n_pass++;
        @(posedge clk);
        @(negedge clk);
        now = {cmd_valid, cmd_op, cmd_buf_addr, cmd_acc_addr, cmd_last};
        n_checks++;
        if (now !== snap) $display("FAIL stall_hold got %h exp %h", now, snap);
        else n_pass++;
        @(posedge clk); #1;
        cmd_ready = 1'b1;
        wait_done(d0 + 1, ok2);
        exp_busy = exp_busy + 32'd5;
        n_checks++;
        if (!ok || !ok2 || done_cnt != d0 + 1)
            $display("FAIL stall_done got accepted=%b dones=%0d exp 1 1", ok, done_cnt - d0);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cmd_t e;
            cmd_t o;
            n_checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0)
                $display("FAIL stall_cmd%0d missing got obs=%0d exp=%0d", i, obs_q.size(), exp_q.size());
            else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL stall_cmd%0d got op=%b buf=%h acc=%h last=%b exp op=%b buf=%h acc=%h last=%b",
                             i, o.op, o.b, o.a, o.last, e.op, e.b, e.a, e.last);
                else n_pass++;
            end
        end
        n_checks++;
        if (obs_q.size() != 0) $display("FAIL stall_extra_handshakes got %0d exp 0", obs_q.size());
        else n_pass++;
        n_checks++;
        if (busy_cycles !== exp_bc()) $display("FAIL stall_busy_cycles got %0d exp %0d", busy_cycles, exp_bc());
        else n_pass++;
    endtask

    task automatic test_illegal_nop_zero();
        int unsigned d0, i0, v0, b0;
        bit ok1, ok2, ok3;
        d0 = done_cnt;
        i0 = ill_cnt;
        v0 = valid_cnt;
        b0 = both_cnt;
        cmd_ready = 1'b1;
        send(8'h07, 24'h000001, 16'h0001, 32'd5, ok1);
        send(8'h00, 24'h000002, 16'h0002, 32'd5, ok2);
        send(8'h02, 24'h000003, 16'h0003, 32'd0, ok3);
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (!(ok1 && ok2 && ok3)) $display("FAIL misc_accept got %b%b%b exp 111", ok1, ok2, ok3);
        else n_pass++;
        n_checks++;
        if (ill_cnt - i0 != 1) $display("FAIL misc_illegal_count got %0d exp 1", ill_cnt - i0);
        else n_pass++;
        n_checks++;
        if (done_cnt - d0 != 2) $display("FAIL misc_done_count got %0d exp 2", done_cnt - d0);
        else n_pass++;
        n_checks++;
        if (valid_cnt != v0 || both_cnt != b0)
            $display("FAIL misc_no_cmd got valid_cycles=%0d overlap=%0d exp 0 0", valid_cnt - v0, both_cnt - b0);
        else n_pass++;
        n_checks++;
        if (busy_cycles !== exp_bc()) $display("FAIL misc_busy_cycles got %0d exp %0d", busy_cycles, exp_bc());
        else n_pass++;
    endtask

    task automatic test_wrap();
        int unsigned d0;
        bit ok;
        bit ok2;
        d0 = done_cnt;
        cmd_ready = 1'b1;
        clear_queues();
        push_cmds(2'b11, 24'hFFFFFE, 16'hFFFF, 3);
        send(8'h03, 24'hFFFFFE, 16'hFFFF, 32'd3, ok);
        wait_done(d0 + 1, ok2);
        exp_busy = exp_busy + 32'd3;
        n_checks++;
        if (!ok || !ok2) $display("FAIL wrap_complete got accepted=%b done_seen=%b exp 1 1", ok, ok2);
        else n_pass++;
        for (int i = 0; i < 3; i++) begin
            cmd_t e;
            cmd_t o;
            n_checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0)
                $display("FAIL wrap_cmd%0d missing got obs=%0d exp=%0d", i, obs_q.size(), exp_q.size());
            else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL wrap_cmd%0d got op=%b buf=%h acc=%h last=%b exp op=%b buf=%h acc=%h last=%b",
                             i, o.op, o.b, o.a, o.last, e.op, e.b, e.a, e.last);
                else n_pass++;
            end
        end
    endtask

    task automatic test_back_to_back();
        int unsigned d0;
        bit ok1, ok2, ok3;
        d0 = done_cnt;
        cmd_ready = 1'b1;
        clear_queues();
        push_cmds(2'b10, 24'h000200, 16'h0300, 2);
        push_cmds(2'b10, 24'h000210, 16'h0310, 2);
        send(8'h02, 24'h000200, 16'h0300, 32'd2, ok1);
        send(8'h02, 24'h000210, 16'h0310, 32'd2, ok2);
        wait_done(d0 + 2, ok3);
        exp_busy = exp_busy + 32'd4;
        n_checks++;
        if (!(ok1 && ok2 && ok3)) $display("FAIL b2b_complete got %b%b%b exp 111", ok1, ok2, ok3);
        else n_pass++;
        n_checks++;
        if (acc_cyc_q.size() != 2 || acc_cyc_q[1] != acc_cyc_q[0] + 3)
            $display("FAIL b2b_bubble got accepts=%0d gap=%0d exp 2 3", acc_cyc_q.size(),
                     (acc_cyc_q.size() == 2) ? acc_cyc_q[1] - acc_cyc_q[0] : 0);
        else n_pass++;
        n_checks++;
        if (acc_cyc_q.size() != 2 || obs_cyc_q.size() != 4 || obs_cyc_q[2] != acc_cyc_q[1] + 1)
            $display("FAIL b2b_second_latency got cmds=%0d exp 4 starting one cycle after accept", obs_cyc_q.size());
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            cmd_t e;
            cmd_t o;
            n_checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0)
                $display("FAIL b2b_cmd%0d missing got obs=%0d exp=%0d", i, obs_q.size(), exp_q.size());
            else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL b2b_cmd%0d got op=%b buf=%h acc=%h last=%b exp op=%b buf=%h acc=%h last=%b",
                             i, o.op, o.b, o.a, o.last, e.op, e.b, e.a, e.last);
                else n_pass++;
            end
        end
        n_checks++;
        if (busy_cycles !== exp_bc()) $display("FAIL b2b_busy_cycles got %0d exp %0d", busy_cycles, exp_bc());
        else n_pass++;
    endtask

    task automatic test_halt();
        bit ok1, ok2;
        int unsigned v0;
        cmd_ready = 1'b1;
        send(8'hFF, 24'h0, 16'h0, 32'd0, ok1);
        @(negedge clk);
        n_checks++;
        if (!ok1 || halted !== 1'b1 || instr_ready !== 1'b0 || cmd_valid !== 1'b0)
            $display("FAIL halt_enter got acc=%b halted=%b ready=%b valid=%b exp 1 1 0 0",
                     ok1, halted, instr_ready, cmd_valid);
        else n_pass++;
        v0 = valid_cnt;
        send(8'h02, 24'h000050, 16'h0050, 32'd4, ok2);
        @(negedge clk);
        n_checks++;
        if (ok2 || halted !== 1'b1 || instr_ready !== 1'b0 || valid_cnt != v0)
            $display("FAIL halt_sticky got acc=%b halted=%b ready=%b valid_cycles=%0d exp 0 1 0 0",
                     ok2, halted, instr_ready, valid_cnt - v0);
        else n_pass++;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        exp_busy = 32'd0;
        @(negedge clk);
        n_checks++;
        if (halted !== 1'b0 || instr_ready !== 1'b1 || busy_cycles !== 32'd0)
            $display("FAIL halt_reset_exit got halted=%b ready=%b bc=%0d exp 0 1 0", halted, instr_ready, busy_cycles);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int unsigned d0;
        bit ok, ok2, ok3;
        cmd_ready = 1'b1;
        clear_queues();
        d0 = done_cnt;
        send(8'h02, 24'h000500, 16'h0600, 32'd8, ok);
        for (int i = 0; i < 20 && obs_q.size() < 2; i++) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (!ok || {cmd_valid, cmd_op, cmd_buf_addr, cmd_acc_addr, cmd_last} !== 44'd0 ||
            instr_ready !== 1'b1 || busy !== 1'b0 || busy_cycles !== 32'd0)
            $display("FAIL resetmid_outputs got acc=%b v=%b buf=%h ready=%b busy=%b bc=%0d exp 1 0 0 1 0 0",
                     ok, cmd_valid, cmd_buf_addr, instr_ready, busy, busy_cycles);
        else n_pass++;
        @(negedge clk);
        rst_n = 1'b1;
        exp_busy = 32'd0;
        repeat (10) @(posedge clk);
        #1;
        n_checks++;
        if (done_cnt != d0) $display("FAIL resetmid_no_done got %0d exp 0", done_cnt - d0);
        else n_pass++;
        clear_queues();
        push_cmds(2'b10, 24'h000700, 16'h0800, 2);
        send(8'h02, 24'h000700, 16'h0800, 32'd2, ok2);
        wait_done(d0 + 1, ok3);
        exp_busy = exp_busy + 32'd2;
        n_checks++;
        if (!ok2 || !ok3) $display("FAIL resetmid_rerun got accepted=%b done_seen=%b exp 1 1", ok2, ok3);
        else n_pass++;
        for (int i = 0; i < 2; i++) begin
            cmd_t e;
            cmd_t o;
            n_checks++;
            if (exp_q.size() == 0 || obs_q.size() == 0)
                $display("FAIL resetmid_cmd%0d missing got obs=%0d exp=%0d", i, obs_q.size(), exp_q.size());
            else begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                if (o !== e)
                    $display("FAIL resetmid_cmd%0d got op=%b buf=%h acc=%h last=%b exp op=%b buf=%h acc=%h last=%b",
                             i, o.op, o.b, o.a, o.last, e.op, e.b, e.a, e.last);
                else n_pass++;
            end
        end
        n_checks++;
        if (busy_cycles !== exp_bc()) $display("FAIL resetmid_busy_cycles got %0d exp %0d", busy_cycles, exp_bc());
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_matmul();
        test_stall();
        test_illegal_nop_zero();
        test_wrap();
        test_back_to_back();
        test_halt();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
